// File: rtl/if_id_buffer_if.sv
// Fetch/decode boundary bundle for the IF/ID buffer.
// The slave modport is the buffer's view and the master modport is the surrounding pipeline's view.
interface if_id_buffer_if;
    logic [31:0] FD_Inst_code;
    logic [31:0] fd_pc;
    logic        fd_valid;
    logic        fd_ready;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rd;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [6:0]  id_funct7;
    logic        id_illegal;
    logic [1:0]  id_count;

    modport slave (
        input  FD_Inst_code, fd_pc, fd_valid, flush, id_ready,
        output fd_ready, id_valid, id_inst, id_pc, id_opcode, id_rd, id_funct3,
               id_rs1, id_rs2, id_funct7, id_illegal, id_count
    );

    modport master (
        output FD_Inst_code, fd_pc, fd_valid, flush, id_ready,
        input  fd_ready, id_valid, id_inst, id_pc, id_opcode, id_rd, id_funct3,
               id_rs1, id_rs2, id_funct7, id_illegal, id_count
    );
endinterface

// File: rtl/if_id_buffer.sv
// Two-entry IF/ID skid FIFO with head-instruction field decode and RV32I opcode legality check.
// Every output is derived from registered state only; there is no same-cycle bypass.
module if_id_buffer #(
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic           clock,
    input  logic           reset,
    if_id_buffer_if.slave  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    logic [XLEN-1:0]  inst_q [DEPTH];
    logic [XLEN-1:0]  pc_q   [DEPTH];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             fd_ready_c;
    logic             id_valid_c;
    logic             push_c;
    logic             pop_c;
    logic [XLEN-1:0]  head_inst_c;
    logic [XLEN-1:0]  head_pc_c;
    logic             legal_op_c;

    assign fd_ready_c = (count_q < CNT_W'(DEPTH));
    assign id_valid_c = (count_q != '0);
    assign push_c     = bus.fd_valid && fd_ready_c && !bus.flush;
    assign pop_c      = id_valid_c && bus.id_ready && !bus.flush;

    // Next-state: flush clears pointers and count and overrides push and pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = ~wr_ptr_q;
            if (pop_c)  rd_ptr_d = ~rd_ptr_q;
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset and is never cleared on pop or flush.
    always_ff @(posedge clock) begin
        if (push_c && !reset) begin
            inst_q[wr_ptr_q] <= bus.FD_Inst_code;
            pc_q[wr_ptr_q]   <= bus.fd_pc;
        end
    end

    assign head_inst_c = id_valid_c ? inst_q[rd_ptr_q] : NOP_INST;
    assign head_pc_c   = id_valid_c ? pc_q[rd_ptr_q]   : '0;

    // RV32I base opcode whitelist; the low two bits must also be 2'b11.
    always_comb begin
        legal_op_c = 1'b0;
        case (head_inst_c[6:0])
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
            7'b0110011, 7'b0001111, 7'b1110011: legal_op_c = 1'b1;
            default:                            legal_op_c = 1'b0;
        endcase
    end

    assign bus.fd_ready   = fd_ready_c;
    assign bus.id_valid   = id_valid_c;
    assign bus.id_inst    = head_inst_c;
    assign bus.id_pc      = head_pc_c;
    assign bus.id_opcode  = head_inst_c[6:0];
    assign bus.id_rd      = head_inst_c[11:7];
    assign bus.id_funct3  = head_inst_c[14:12];
    assign bus.id_rs1     = head_inst_c[19:15];
    assign bus.id_rs2     = head_inst_c[24:20];
    assign bus.id_funct7  = head_inst_c[31:25];
    assign bus.id_illegal = id_valid_c && !legal_op_c;
    assign bus.id_count   = count_q;
endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
- REQ-001: Parameter NOP_INST, default 32'h00000013, is the instruction presented on id_inst while the buffer is empty.
- REQ-002: clock  input  1  single clock; all state updates on the rising edge.
- REQ-003: reset  input  1  synchronous, active-high reset, sampled on the rising clock edge.
- REQ-004: FD_Inst_code  input  32  instruction word from fetch.
- REQ-005: fd_pc  input  32  PC of FD_Inst_code.
- REQ-006: fd_valid  input  1  fetch offers FD_Inst_code/fd_pc this cycle.
- REQ-007: fd_ready  output  1  buffer can accept a word this cycle.
- REQ-008: flush  input  1  discard all buffered and incoming words (branch/jump redirect).
- REQ-009: id_valid  output  1  head entry valid for decode.
- REQ-010: id_ready  input  1  decode consumes the head entry this cycle.
- REQ-011: id_inst  output  32  head instruction.
- REQ-012: id_pc  output  32  head PC.
- REQ-013: id_opcode 7, id_rd 5, id_funct3 3, id_rs1 5, id_rs2 5, id_funct7 7  outputs  fields of id_inst: [6:0], [11:7], [14:12], [19:15], [24:20], [31:25].
- REQ-014: id_illegal  output  1  head instruction not a recognised RV32I base opcode.
- REQ-015: id_count  output  2  current occupancy, 0..2.

Function
- REQ-016: Storage is a 2-entry FIFO of {inst, pc} pairs with 1-bit read pointer, 1-bit write pointer, and a 2-bit count.
- REQ-017: fd_ready = (count < 2), derived from registered state only; there is no combinational path from id_ready or flush to fd_ready.
- REQ-018: A push occurs when fd_valid && fd_ready && !flush; FD_Inst_code and fd_pc are written at the write pointer, which then increments modulo 2.
- REQ-019: id_valid = (count != 0).
- REQ-020: A pop occurs when id_valid && id_ready && !flush; the read pointer increments modulo 2.
- REQ-021: Count update: push only -> +1; pop only -> -1; push and pop together -> unchanged.
- REQ-022: A push in the same cycle as a pop at count 1 is accepted; the popped word leaves and the new word becomes the head next cycle.
- REQ-023: At count 2, the incoming word is not accepted (fd_ready=0), even when a pop occurs that cycle.
- REQ-024: Pop latency: a word pushed into an empty buffer appears on id_inst/id_pc with id_valid=1 in the following cycle; there is no same-cycle bypass.
- REQ-025: On flush=1, the next state has count=0, read pointer=0, write pointer=0; any simultaneous push or pop is ignored; flush has priority over push and pop.
- REQ-026: When count=0, id_inst=NOP_INST and id_pc=32'h0; id_illegal=0; field outputs decode NOP_INST.
- REQ-027: When count!=0, id_inst/id_pc show the entry at the read pointer.
- REQ-028: id_illegal=1 iff id_valid && (id_inst[1:0]!=2'b11 || id_opcode is not one of 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011).
- REQ-029: id_count equals the count register.
- REQ-030: Entry data is not cleared on pop or flush; only the pointers and count change.

Reset
- REQ-031: When reset=1 at a clock edge: count=0, read pointer=0, write pointer=0; id_valid=0, fd_ready=1, id_inst=NOP_INST, id_pc=0, id_illegal=0, id_count=0 from the next cycle.
- REQ-032: Reset has priority over flush, push and pop.
- REQ-033: A reset asserted mid-operation discards all buffered words.
- REQ-034: Storage array contents need no reset.

Verification
- REQ-035: Reset, then push {32'h00500093, pc 0} with id_ready=0 -> next cycle id_valid=1, id_inst=32'h00500093, id_rd=1, id_opcode=7'h13, id_count=1.
- REQ-036: Push pc 0 and pc 4 with id_ready=0 -> id_count=2, fd_ready=0; a third word offered is not accepted; pop -> head pc 4.
- REQ-037: At count 1, push pc 8 and pop in the same cycle -> id_count stays 1; next head pc=8.
- REQ-038: At count 2, flush=1 with fd_valid=1 -> next cycle id_count=0, id_valid=0, id_inst=32'h00000013, fd_ready=1.
- REQ-039: Push 32'h0000007F -> id_illegal=1; push 32'h00000073 -> id_illegal=0.
- REQ-040: At count 2, assert reset together with flush, fd_valid and id_ready -> all outputs at reset values on the next cycle.
